// File: rtl/muldiv_unit.sv
// Iterative 33-cycle multiply/divide unit with architectural HI/LO registers.
// Optional MADD/MADDU accumulation is enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic [1:0]       HiLoWrite,
    input  logic [WIDTH-1:0] HiLoData,
`ifdef MULDIV_MADD_EN
    input  logic             Accumulate,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic             acc_q, acc_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             signed_op;
    logic             acc_req;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] mul_res;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_dword(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // MULT and DIV are the signed encodings (Op[0] == 0).
    assign signed_op = ~Op[0];

`ifdef MULDIV_MADD_EN
    assign acc_req = Accumulate & ~Op[1];
`else
    assign acc_req = 1'b0;
`endif

    always_comb begin
        addend  = quo_q[0] ? opb_q : '0;
        sum     = {1'b0, rem_q[WIDTH-1:0]} + {1'b0, addend};
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, opb_q};
        prod_s  = neg_dword({rem_q[WIDTH-1:0], quo_q}, neg_res_q);
        mul_res = acc_q ? ({hi_q, lo_q} + prod_s) : prod_s;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    is_div_d  = Op[1];
                    neg_res_d = signed_op & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
                    neg_rem_d = signed_op & OperandA[WIDTH-1];
                    div0_d    = Op[1] & (OperandB == '0);
                    acc_d     = acc_req;
                    rem_d     = '0;
                    quo_d     = abs_val(OperandA, signed_op);
                    opb_d     = abs_val(OperandB, signed_op);
                end else begin
                    if (HiLoWrite[1]) hi_d = HiLoData;
                    if (HiLoWrite[0]) lo_d = HiLoData;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {CNT_W{1'b1}}) state_d = S_FIX;
                if (is_div_q) begin
                    // Restoring step: keep the trial difference only when it did not borrow.
                    if (!diff[WIDTH]) begin
                        rem_d = diff;
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted;
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    rem_d = {1'b0, sum[WIDTH:1]};
                    quo_d = {sum[0], quo_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // A zero divisor leaves |dividend| in the remainder, so the sign fix restores OperandA.
                    hi_d = neg_word(rem_q[WIDTH-1:0], neg_rem_q);
                    lo_d = div0_q ? '1 : neg_word(quo_q, neg_res_q);
                end else begin
                    hi_d = mul_res[2*WIDTH-1:WIDTH];
                    lo_d = mul_res[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            acc_q     <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign Busy = (state_q != S_IDLE);
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (MADD vectors under MULDIV_MADD_EN).
module tb_muldiv_unit;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic [1:0]  HiLoWrite;
    logic [31:0] HiLoData;
    logic        acc_in;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .HiLoWrite (HiLoWrite),
        .HiLoData  (HiLoData),
`ifdef MULDIV_MADD_EN
        .Accumulate(acc_in),
`endif
        .Busy      (Busy),
        .Done      (Done),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (Done !== 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge Clock);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic acc,
                          input logic [31:0] eh, input logic [31:0] el);
        int busy_n;
        int n;
        @(negedge Clock);
        Start = 1'b1; Op = op; OperandA = a; OperandB = b; acc_in = acc;
        @(negedge Clock);
        Start = 1'b0; acc_in = 1'b0;
        busy_n = 0;
        n = 0;
        while (Done !== 1'b1 && n < 40) begin
            if (Busy === 1'b1) busy_n++;
            n++;
            @(negedge Clock);
        end
        chk({tag, "_busycycles"}, busy_n, 33);
        chk({tag, "_done"}, Done, 1);
        chk({tag, "_busy_in_done"}, Busy, 0);
        chk({tag, "_hi"}, Hi, eh);
        chk({tag, "_lo"}, Lo, el);
        @(negedge Clock);
        chk({tag, "_done_pulse"}, Done, 0);
    endtask

    initial begin
        int cyc;
        int seen;
        Reset = 1'b0; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
        HiLoWrite = 2'b00; HiLoData = '0; acc_in = 1'b0;
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_hi", Hi, 0);
        chk("rst_lo", Lo, 0);
        @(negedge Clock);
        Reset = 1'b1;

        run_op("mult_7x-3", 2'b00, 32'd7, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_minmin", 2'b00, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000);
        run_op("div_-7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7/-2", 2'b10, 32'd7, 32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu_100/7", 2'b11, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
        run_op("divu_100/0", 2'b11, 32'd100, 32'd0, 1'b0, 32'd100, 32'hFFFFFFFF);
        run_op("div_-7/0", 2'b10, 32'hFFFFFFF9, 32'd0, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000);

        // Start and HiLoWrite while busy are both dropped.
        @(negedge Clock);
        Start = 1'b1; Op = 2'b01; OperandA = 32'd3; OperandB = 32'd5;
        @(negedge Clock);
        Start = 1'b0;
        repeat (9) @(negedge Clock);
        Start = 1'b1; Op = 2'b11; OperandA = 32'd9; OperandB = 32'd3;
        @(negedge Clock);
        Start = 1'b0;
        @(negedge Clock);
        HiLoWrite = 2'b11; HiLoData = 32'h0000AAAA;
        @(negedge Clock);
        HiLoWrite = 2'b00;
        chk("busy_hold_hi", Hi, 32'h00000000);
        chk("busy_hold_lo", Lo, 32'h80000000);
        chk("busy_still", Busy, 1);
        wait_done(cyc);
        chk("ignore_done", Done, 1);
        chk("ignore_hi", Hi, 32'h00000000);
        chk("ignore_lo", Lo, 32'd15);
        @(negedge Clock);
        HiLoWrite = 2'b10; HiLoData = 32'h00001234;
        @(negedge Clock);
        HiLoWrite = 2'b00;
        chk("mthi_hi", Hi, 32'h00001234);
        chk("mthi_lo", Lo, 32'd15);

        // Start wins over a simultaneous HiLoWrite.
        @(negedge Clock);
        Start = 1'b1; Op = 2'b01; OperandA = 32'd2; OperandB = 32'd3;
        HiLoWrite = 2'b11; HiLoData = 32'h5555;
        @(negedge Clock);
        Start = 1'b0; HiLoWrite = 2'b00;
        chk("startwins_hi", Hi, 32'h00001234);
        chk("startwins_lo", Lo, 32'd15);
        wait_done(cyc);
        chk("startwins_res", {Hi, Lo}, 64'd6);

        // Asynchronous reset mid-operation.
        @(negedge Clock);
        Start = 1'b1; Op = 2'b00; OperandA = 32'd6; OperandB = 32'd7;
        @(negedge Clock);
        Start = 1'b0;
        repeat (19) @(negedge Clock);
        #2 Reset = 1'b0;
        #1;
        chk("arst_busy", Busy, 0);
        chk("arst_hi", Hi, 0);
        chk("arst_lo", Lo, 0);
        @(negedge Clock);
        Reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (Done === 1'b1 || Busy === 1'b1) seen++;
        end
        chk("arst_no_done", seen, 0);
        run_op("mult_6x7", 2'b00, 32'd6, 32'd7, 1'b0, 32'd0, 32'd42);

`ifdef MULDIV_MADD_EN
        @(negedge Clock);
        HiLoWrite = 2'b11; HiLoData = 32'hFFFFFFFF;
        @(negedge Clock);
        HiLoWrite = 2'b10; HiLoData = 32'h00000000;
        @(negedge Clock);
        HiLoWrite = 2'b00;
        run_op("maddu_1x1", 2'b01, 32'd1, 32'd1, 1'b1, 32'd1, 32'd0);
        run_op("madd_neg", 2'b00, 32'd2, 32'hFFFFFFFF, 1'b1, 32'd0, 32'hFFFFFFFE);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the mips32 core.
- Sits directly downstream of the register file. Operands come from ReadData1/ReadData2.
- Its HI/LO outputs feed the write-back mux for MFHI/MFLO, so results return to the register file.
- Executes MULT, MULTU, DIV and DIVU in a fixed 33 cycles. Also supports MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits. The core uses only 32; the bench covers only 32.
- CNT_W, 5, iteration counter width. Must equal log2(WIDTH).

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset. 0 clears all state immediately.
- Start  input  1  launch an operation. Sampled on the rising edge.
- Op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- OperandA  input  WIDTH  rs value: multiplicand or dividend.
- OperandB  input  WIDTH  rt value: multiplier or divisor.
- HiLoWrite  input  2  bit1 = MTHI, bit0 = MTLO.
- HiLoData  input  WIDTH  data for MTHI/MTLO.
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse when HI/LO have been updated by an operation.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State goes to IDLE; counter=0; Busy=0; Done=0; Hi=0; Lo=0.
  - An operation in flight is discarded.
  - After Reset returns to 1, operation resumes on the next edge.
- States:
  - IDLE: Start=1 on an edge latches Op and both operands, then goes to RUN.
    - Signed ops latch absolute values plus result-sign flags.
    - counter=0; Busy=1 from the next cycle.
  - RUN, 32 cycles, one bit per cycle:
    - Multiply: radix-2 shift-add into a 64-bit accumulator.
    - Divide: restoring shift-subtract, giving quotient and remainder.
    - After the edge where counter==31, go to FIX.
  - FIX, 1 cycle: apply sign correction, write Hi/Lo on the exiting edge, go to IDLE.
    - Done=1 for exactly the following cycle; Busy=0 in that cycle.
- Latency: Start sampled at edge E0 gives Busy=1 for the 33 cycles after E0. Hi/Lo update at edge E33, with Done=1 in the cycle after E33.
- Multiply result: Hi=product[63:32], Lo=product[31:0]. MULT is two's-complement signed; MULTU is unsigned.
- Divide result: Lo=quotient, Hi=remainder.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide boundary cases:
  - Divisor 0 (DIV or DIVU): Hi=OperandA, Lo=all ones.
  - Signed 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0.
- Start while Busy=1: ignored. Latched operands are unchanged and there is no error signal.
- Start in the Done cycle: accepted, since the state is IDLE.
- HiLoWrite:
  - Takes effect only in IDLE with Start=0; Hi and/or Lo load HiLoData on the edge.
  - Ignored while Busy=1 or when Start=1 in the same cycle (Start wins).
- Hi/Lo hold their value during RUN. Intermediate values are never visible.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined:
  - Extra input port Accumulate (1 bit), sampled with Start. Meaningful only with Op 00 or 01.
  - Accumulate=1 makes the FIX write {Hi,Lo} = {Hi,Lo} + product (MADD/MADDU). The 64-bit sum wraps modulo 2^64.
  - Latency is unchanged at 33 cycles.
- Undefined:
  - The Accumulate port does not exist.
  - All multiplies overwrite HI/LO.

Test Plan:
- MULT, OperandA=7, OperandB=0xFFFFFFFD (-3) -> Busy high 33 cycles; Done pulse; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- MULTU, 0xFFFFFFFF × 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV, 0xFFFFFFF9 (-7) / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Then DIVU 100/0 -> Hi=100, Lo=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Start MULTU 3×5, then pulse Start with DIVU 9/3 at cycle 10 and HiLoWrite=11 with HiLoData=0xAAAA at cycle 12 -> both ignored; Hi=0, Lo=15. In IDLE, HiLoWrite=10 with 0x1234 -> Hi=0x1234, Lo unchanged.
- Start MULT 6×7, drop Reset at cycle 20 -> Busy=0, Hi=Lo=0 immediately and no Done pulse. After release, MULT 6×7 -> Lo=42.
- With MULDIV_MADD_EN: Hi=0, Lo=0xFFFFFFFF, MADDU 1×1 -> Hi=1, Lo=0.
